// File: rtl/ins_mem_ld.sv
// ins_mem_ld: writable instruction memory for the fetch stage.
// After reset a sweep fills every entry with NOP_INS. The block then serves
// registered fetches addressed by PC (RUN) and, on request, accepts a new
// program through a valid/ready streaming port (LOAD).
module ins_mem_ld #(
  parameter int                 INS_W   = 16,
  parameter int                 ADDR_W  = 4,
  parameter logic [INS_W-1:0]   NOP_INS = 16'h0300
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC,
  input  logic              FETCH,
  output logic [INS_W-1:0]  INS,
  output logic              INS_VALID,
  output logic              READY,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [INS_W-1:0]  LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_DONE
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;

  // Shared write pointer: the clear sweep and the program load never overlap.
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  ptr_n;

  logic               wr_en;
  logic [INS_W-1:0]   wr_data;
  logic               rd_en;
  logic               done_n;

  logic [INS_W-1:0]   mem [DEPTH];

  // Next-state, write-port and handshake decode for the CLEAR/RUN/LOAD sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n  = state;
    ptr_n    = ptr;
    wr_en    = 1'b0;
    wr_data  = LD_DATA;
    rd_en    = 1'b0;
    done_n   = 1'b0;
    READY    = 1'b0;
    LD_READY = 1'b0;

    unique case (state)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_data = NOP_INS;
        ptr_n   = ptr + ADDR_ONE;
        if (ptr == LAST_ADDR) begin
          state_n = S_RUN;
          ptr_n   = '0;
        end
      end

      S_RUN: begin
        READY = 1'b1;
        // A fetch in the same cycle as LD_START still reads the old contents.
        rd_en = FETCH;
        if (LD_START) begin
          state_n = S_LOAD;
          ptr_n   = '0;
        end
      end

      S_LOAD: begin
        LD_READY = 1'b1;
        if (LD_VALID) begin
          wr_en = 1'b1;
          ptr_n = ptr + ADDR_ONE;
          // A full-depth load ends by itself; the pointer wraps to 0.
          if (LD_LAST || (ptr == LAST_ADDR)) begin
            state_n = S_RUN;
            done_n  = 1'b1;
          end
        end
      end

      default: begin
        state_n = S_CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  // Sequencer state, pointer and one-cycle status pulses; reset restarts the sweep.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST_N) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      INS_VALID <= 1'b0;
      LD_DONE   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      INS_VALID <= rd_en;
      LD_DONE   <= done_n;
    end
  end

  // Registered read port: INS updates only on an accepted fetch, else holds.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      INS <= NOP_INS;
    end else if (rd_en) begin
      INS <= mem[PC];
    end
  end

  // Single write port shared by the clear sweep and the program load.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset branch; the post-reset sweep initialises it,
    // which keeps it a plain register file instead of DEPTH resettable flops.
    if (wr_en && RST_N) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ins_mem_ld.sv
// tb_ins_mem_ld: directed self-checking bench for ins_mem_ld.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_ins_mem_ld;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pc;
  logic        fetch;
  logic [15:0] ins;
  logic        ins_valid;
  logic        ready;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;

  int total = 0;
  int bad   = 0;

  ins_mem_ld #(
    .INS_W  (16),
    .ADDR_W (4),
    .NOP_INS(16'h0300)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .PC       (pc),
    .FETCH    (fetch),
    .INS      (ins),
    .INS_VALID(ins_valid),
    .READY    (ready),
    .LD_START (ld_start),
    .LD_VALID (ld_valid),
    .LD_DATA  (ld_data),
    .LD_LAST  (ld_last),
    .LD_READY (ld_ready),
    .LD_DONE  (ld_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle fetch; INS must carry the expected word with INS_VALID high.
  task automatic do_fetch(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    pc    = addr;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check({tag, "_ins"}, ins, exp);
    check({tag, "_valid"}, 16'(ins_valid), 16'd1);
  endtask

  // Send one load word; LD_DONE after the edge must match done_exp.
  task automatic ld_word(input logic [15:0] data, input logic last, input logic done_exp,
                         input string tag);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check({tag, "_done"}, 16'(ld_done), 16'(done_exp));
  endtask

  initial begin
    int n;
    int vcnt;

    rst_n    = 1'b0;
    pc       = '0;
    fetch    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;

    // Reset state.
    tick();
    check("rst_ins", ins, 16'h0300);
    check("rst_ins_valid", 16'(ins_valid), 16'd0);
    check("rst_ready", 16'(ready), 16'd0);
    check("rst_ld_ready", 16'(ld_ready), 16'd0);
    check("rst_ld_done", 16'(ld_done), 16'd0);

    // Clear sweep: 16 cycles with READY low; FETCH and LD_START ignored.
    rst_n    = 1'b1;
    fetch    = 1'b1;
    ld_start = 1'b1;
    pc       = 4'd3;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c < 16) begin
        check($sformatf("clr_ready_%0d", c), 16'(ready), 16'd0);
        check($sformatf("clr_valid_%0d", c), 16'(ins_valid), 16'd0);
      end
    end
    ld_start = 1'b0;
    check("clr_ready_up", 16'(ready), 16'd1);
    check("clr_ld_ready", 16'(ld_ready), 16'd0);
    check("clr_no_fetch", 16'(ins_valid), 16'd0);

    // Back-to-back fetches of every entry: all NOP, 16 consecutive valids.
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      pc    = 4'(i);
      fetch = 1'b1;
      tick();
      check($sformatf("nop_ins_%0d", i), ins, 16'h0300);
      if (ins_valid) vcnt++;
    end
    fetch = 1'b0;
    check("b2b_valid_count", 16'(vcnt), 16'd16);
    tick();
    check("idle_valid", 16'(ins_valid), 16'd0);
    check("idle_ins_hold", ins, 16'h0300);

    // Full-depth load, no LD_LAST: auto-exit after word 15.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("full_ld_ready", 16'(ld_ready), 16'd1);
    check("full_ready_low", 16'(ready), 16'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_accept_rdy_%0d", i), 16'(ld_ready), 16'd1);
      ld_word(16'h1000 + 16'(i), 1'b0, (i == 15), $sformatf("full_w%0d", i));
    end
    check("full_exit_ready", 16'(ready), 16'd1);
    check("full_exit_ld_ready", 16'(ld_ready), 16'd0);
    tick();
    check("full_done_pulse", 16'(ld_done), 16'd0);
    do_fetch(4'd5, 16'h1005, "full_pc5");
    do_fetch(4'd0, 16'h1000, "full_pc0");
    do_fetch(4'd15, 16'h100F, "full_pc15");

    // Short load terminated by LD_LAST on the third word.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_word(16'hA000, 1'b0, 1'b0, "short_w0");
    ld_word(16'hA001, 1'b0, 1'b0, "short_w1");
    ld_word(16'hA002, 1'b1, 1'b1, "short_w2");
    check("short_exit_ready", 16'(ready), 16'd1);
    do_fetch(4'd2, 16'hA002, "short_pc2");
    do_fetch(4'd3, 16'h1003, "short_pc3_kept");
    do_fetch(4'd0, 16'hA000, "short_pc0");

    // Load with LD_VALID gaps and a FETCH attempt while in LOAD.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    fetch    = 1'b1;
    pc       = 4'd2;
    ld_word(16'hB000, 1'b0, 1'b0, "gap_w0");
    fetch    = 1'b0;
    check("gap_fetch_no_valid", 16'(ins_valid), 16'd0);
    check("gap_fetch_ins_hold", ins, 16'hA000);
    ld_valid = 1'b0;
    ld_data  = 16'hDEAD;
    ld_last  = 1'b1;
    tick();
    ld_last  = 1'b0;
    check("gap_idle_done", 16'(ld_done), 16'd0);
    check("gap_idle_ld_ready", 16'(ld_ready), 16'd1);
    ld_word(16'hB001, 1'b0, 1'b0, "gap_w1");
    ld_data = 16'hDEAD;
    tick();
    check("gap_idle2_done", 16'(ld_done), 16'd0);
    ld_word(16'hB002, 1'b1, 1'b1, "gap_w2");
    do_fetch(4'd0, 16'hB000, "gap_pc0");
    do_fetch(4'd1, 16'hB001, "gap_pc1");
    do_fetch(4'd2, 16'hB002, "gap_pc2");
    do_fetch(4'd3, 16'h1003, "gap_pc3_kept");

    // LD_START together with FETCH: fetch served from old contents, then LOAD.
    pc       = 4'd1;
    fetch    = 1'b1;
    ld_start = 1'b1;
    tick();
    fetch    = 1'b0;
    ld_start = 1'b0;
    check("both_ins", ins, 16'hB001);
    check("both_valid", 16'(ins_valid), 16'd1);
    check("both_ld_ready", 16'(ld_ready), 16'd1);
    check("both_ready", 16'(ready), 16'd0);

    // Reset mid-load after two words.
    ld_word(16'hC000, 1'b0, 1'b0, "mid_w0");
    ld_word(16'hC001, 1'b0, 1'b0, "mid_w1");
    rst_n = 1'b0;
    tick();
    check("mid_rst_ins", ins, 16'h0300);
    check("mid_rst_valid", 16'(ins_valid), 16'd0);
    check("mid_rst_ready", 16'(ready), 16'd0);
    check("mid_rst_ld_ready", 16'(ld_ready), 16'd0);
    check("mid_rst_ld_done", 16'(ld_done), 16'd0);
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check("mid_sweep_len", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) begin
      do_fetch(4'(i), 16'h0300, $sformatf("post_pc%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ins_mem_ld.md
Name: ins_mem_ld

Overview:
- Parametrised, writable instruction memory for the CPU fetch stage; replaces the fixed hard-wired program ROM.
- Holds DEPTH instructions of INS_W bits and serves registered fetches addressed by PC.
- Accepts a new program through a streaming load port with a valid/ready handshake.
- A sequencer clears memory to NOP after reset, then arbitrates between run (fetch) and load modes.

Parameters:
INS_W, 16, instruction width in bits
ADDR_W, 4, PC/address width; DEPTH = 2**ADDR_W entries
NOP_INS, 16'h0300, fill value written to every entry by the clear sweep

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  synchronous active-low reset
PC  input  ADDR_W  fetch address
FETCH  input  1  fetch request, sampled when READY=1
INS  output  INS_W  fetched instruction, registered
INS_VALID  output  1  one-cycle pulse: INS updated this cycle
READY  output  1  high only in RUN; fetches accepted
LD_START  input  1  request program load (honoured in RUN only)
LD_VALID  input  1  LD_DATA valid
LD_DATA  input  INS_W  program word
LD_LAST  input  1  qualifies final word when LD_VALID=1
LD_READY  output  1  high only in LOAD
LD_DONE  output  1  one-cycle pulse after the final load word is written

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - INS=NOP_INS; INS_VALID=0, READY=0, LD_READY=0, LD_DONE=0.
  - Clear pointer=0; state=CLEAR.
  - Reset overrides everything, including mid-load or mid-clear, and restarts the sweep.
- FSM states: CLEAR, RUN, LOAD.
- CLEAR:
  - Writes NOP_INS to entry at pointer each cycle, pointer+1.
  - After entry DEPTH-1 is written: state=RUN, pointer=0.
  - Takes exactly DEPTH cycles; READY rises on the cycle after the last write.
  - FETCH and LD_START are ignored.
- RUN:
  - READY=1.
  - FETCH=1 at an edge: INS<=mem[PC], INS_VALID=1 for the next cycle. Latency is 1 cycle; throughput is 1 fetch/cycle.
  - FETCH=0: INS holds its last value; INS_VALID=0.
  - LD_START=1 at an edge: state=LOAD, load pointer=0.
  - LD_START and FETCH together: the fetch is served from the old contents, then LOAD is entered.
- LOAD:
  - READY=0, LD_READY=1; FETCH is ignored (no INS_VALID); INS holds.
  - A word is accepted when LD_VALID=1 at an edge: mem[pointer]<=LD_DATA, pointer+1 (ADDR_W bits).
  - Termination: the accepted word has LD_LAST=1, or the pointer was DEPTH-1 (pointer wraps to 0 internally).
  - On termination: state=RUN next cycle and LD_DONE=1 for exactly that cycle.
  - Entries not written in a short load keep their previous contents.
  - LD_START in LOAD is ignored.
- Memory array: DEPTH x INS_W registers; single write port (clear or load), single registered read port. Read and write are never concurrent because the modes are exclusive.
- Widths: PC is used directly as the index with no bounds check, since DEPTH=2**ADDR_W. Load pointer arithmetic is modulo DEPTH.
- Signals outside their active state (LD_VALID/LD_LAST in RUN, FETCH in LOAD/CLEAR) have no effect.

Test Plan:
- Reset, then idle 16 cycles: READY=0 throughout, rises on cycle 17. Fetch PC=0..15 -> each INS=16'h0300 one cycle after FETCH, INS_VALID pulses; back-to-back fetches give 16 consecutive valids.
- LD_START, then stream 16 words 16'h1000+i, LD_LAST=0 -> LD_READY high for 16 accepts, auto-exit after word 15, LD_DONE single pulse. Fetch PC=5 -> INS=16'h1005.
- LD_START, words 16'hA000, 16'hA001, 16'hA002 with LD_LAST on the third -> LD_DONE after 3 accepts. PC=2 -> 16'hA002; PC=3 -> previous contents (16'h1003).
- Load with LD_VALID gaps (valid every other cycle) -> only valid cycles write. FETCH asserted during LOAD -> no INS_VALID, INS unchanged.
- LD_START with FETCH PC=1 in the same cycle -> INS=old mem[1] with INS_VALID, then LOAD entered.
- RST_N low mid-load after 2 words -> outputs reset. After the 16-cycle sweep every PC reads 16'h0300, with no residue of the partial load.
